// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths and next-PC source select codes for the CPU core
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int WORD_W           = 16;
    localparam int RA_DEPTH_DEFAULT = 8;

    // Next-PC source mux select values
    localparam logic [1:0] PCSRC_IMM = 2'd0;
    localparam logic [1:0] PCSRC_RA  = 2'd1;
    localparam logic [1:0] PCSRC_ALU = 2'd2;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/ra_stack.sv
// ============================================================================
// ra_stack : circular return-address stack with sticky overflow/underflow
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ra_stack
    import cpu_pkg::*;
#(
    parameter  int DEPTH = RA_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] push_data,
    input  logic              clear_err,
    output logic [WORD_W-1:0] ra_out,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     sp;
    logic [WORD_W-1:0] top_q;

    logic [AW-1:0] sp_m1;
    logic [AW-1:0] sp_m2;
    logic          is_replace;
    logic          is_push;
    logic          is_pop;
    logic          is_under;
    logic          is_over;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    assign sp_m1 = sp - AW'(1);
    assign sp_m2 = sp - AW'(2);

    // Push+pop on an empty stack degrades to a plain push
    assign is_replace = push & pop & ~empty;
    assign is_push    = push & ~is_replace;
    assign is_pop     = pop & ~push & ~empty;
    assign is_under   = pop & ~push & empty;
    assign is_over    = is_push & full;

    assign ra_out = top_q;

    // Storage is left unreset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (is_push) begin
            mem[sp] <= push_data;
        end else if (is_replace) begin
            mem[sp_m1] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= '0;
            count     <= '0;
            top_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (is_push) begin
                sp    <= sp + AW'(1);
                top_q <= push_data;
                if (!full) begin
                    count <= count + 1'b1;
                end
            end else if (is_replace) begin
                top_q <= push_data;
            end else if (is_pop) begin
                sp    <= sp_m1;
                count <= count - 1'b1;
                // Look two slots back so the new top is ready next cycle
                top_q <= (count > (AW + 1)'(1)) ? mem[sp_m2] : '0;
            end

            overflow  <= is_over  | (overflow  & ~clear_err);
            underflow <= is_under | (underflow & ~clear_err);
        end
    end

endmodule : ra_stack

`default_nettype wire

// File: tb/tb_ra_stack.sv
// ============================================================================
// tb_ra_stack : directed self-checking bench for ra_stack (DEPTH = 8)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ra_stack;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic [15:0] push_data;
    logic        clear_err;
    logic [15:0] ra_out;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    ra_stack #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clear_err (clear_err),
        .ra_out    (ra_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns 1 ns after the capturing edge
    task automatic op(input logic p, input logic q, input logic [15:0] d, input logic clr);
        push      = p;
        pop       = q;
        push_data = d;
        clear_err = clr;
        @(posedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = 16'h0000;
        clear_err = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ra"},    32'(ra_out),    32'h0);
        check({tag, ".cnt"},   32'(count),     32'd0);
        check({tag, ".empty"}, 32'(empty),     32'd1);
        check({tag, ".full"},  32'(full),      32'd0);
        check({tag, ".ovf"},   32'(overflow),  32'd0);
        check({tag, ".unf"},   32'(underflow), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = 16'h0000;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        op(1'b0, 1'b0, 16'h0, 1'b0);
        check_idle("reset");

        // LIFO order
        op(1'b1, 1'b0, 16'h0010, 1'b0);
        op(1'b1, 1'b0, 16'h0020, 1'b0);
        op(1'b1, 1'b0, 16'h0030, 1'b0);
        check("lifo.ra3",  32'(ra_out), 32'h0030);
        check("lifo.cnt3", 32'(count),  32'd3);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("lifo.ra2",  32'(ra_out), 32'h0020);
        check("lifo.cnt2", 32'(count),  32'd2);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("lifo.ra1",  32'(ra_out), 32'h0010);
        check("lifo.cnt1", 32'(count),  32'd1);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("lifo.ra0",  32'(ra_out), 32'h0000);
        check("lifo.cnt0", 32'(count),  32'd0);
        check("lifo.empty", 32'(empty), 32'd1);

        // Fill past capacity: oldest entry (0001) is overwritten
        for (int i = 1; i <= 9; i++) begin
            op(1'b1, 1'b0, 16'(i), 1'b0);
            if (i == 8) begin
                check("fill.full8", 32'(full), 32'd1);
                check("fill.ovf8",  32'(overflow), 32'd0);
            end
        end
        check("ovf.full", 32'(full),     32'd1);
        check("ovf.cnt",  32'(count),    32'd8);
        check("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 9; i >= 2; i--) begin
            check($sformatf("drain.ra%0d", i), 32'(ra_out), 32'(i));
            op(1'b0, 1'b1, 16'h0, 1'b0);
        end
        check("drain.ra_end", 32'(ra_out), 32'h0);
        check("drain.cnt",    32'(count),  32'd0);
        check("drain.ovf",    32'(overflow), 32'd1);
        check("drain.unf",    32'(underflow), 32'd0);
        op(1'b0, 1'b0, 16'h0, 1'b1);
        check("ovf.clr", 32'(overflow), 32'd0);

        // Underflow and clear priority
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("unf.flag", 32'(underflow), 32'd1);
        check("unf.cnt",  32'(count),     32'd0);
        check("unf.ra",   32'(ra_out),    32'h0);
        op(1'b0, 1'b0, 16'h0, 1'b1);
        check("unf.clr", 32'(underflow), 32'd0);
        op(1'b0, 1'b1, 16'h0, 1'b1);
        check("unf.setwins", 32'(underflow), 32'd1);
        op(1'b0, 1'b0, 16'h0, 1'b1);

        // Tail-call replace
        op(1'b1, 1'b0, 16'h00A0, 1'b0);
        op(1'b1, 1'b1, 16'h00B0, 1'b0);
        check("rep.cnt", 32'(count),  32'd1);
        check("rep.ra",  32'(ra_out), 32'h00B0);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("rep.popcnt", 32'(count), 32'd0);
        op(1'b1, 1'b1, 16'h00C0, 1'b0);
        check("repe.cnt", 32'(count),     32'd1);
        check("repe.ra",  32'(ra_out),    32'h00C0);
        check("repe.unf", 32'(underflow), 32'd0);
        op(1'b0, 1'b1, 16'h0, 1'b0);

        // Replace must hit the top slot only, leaving the entry below intact
        op(1'b1, 1'b0, 16'h0011, 1'b0);
        op(1'b1, 1'b0, 16'h0022, 1'b0);
        op(1'b1, 1'b1, 16'h0033, 1'b0);
        check("rep2.ra",  32'(ra_out), 32'h0033);
        check("rep2.cnt", 32'(count),  32'd2);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("rep2.below", 32'(ra_out), 32'h0011);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("rep2.empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-period
        op(1'b1, 1'b0, 16'h0101, 1'b0);
        op(1'b1, 1'b0, 16'h0202, 1'b0);
        op(1'b1, 1'b0, 16'h0303, 1'b0);
        check("pre_rst.cnt", 32'(count), 32'd3);
        #3 reset = 1'b1;
        #1;
        check_idle("arst");
        #2 reset = 1'b0;
        op(1'b0, 1'b0, 16'h0, 1'b0);
        check("post_rst.empty", 32'(empty), 32'd1);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        check("post_rst.unf", 32'(underflow), 32'd1);
        check("post_rst.cnt", 32'(count),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ra_stack

`default_nettype wire
